timed_flag_capture: RTL
=======================

# timed_flag_capture

Producer counterpart of the timed flag reader. While running, it timestamps every cycle on which the input event flag is set and stores the timestamps in one half of a ping-pong internal memory. On the next `run`, it burst-writes that half to external memory over the databus. The output is exactly the table format the timed flag reader later loads and compares against its time input.

## Interface
- `SIZE_W`, 16: width of a stored timestamp.
- `ADDR_W`, 16: internal memory address width; the MSB selects the ping-pong half.
- `AXI_ADDR_W`, 32: databus address width.
- `AXI_DATA_W`, 32: databus and memory word width; each timestamp is zero-extended to this width.
- `LEN_W`, 8: burst length field width.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `running` in 1: accelerator run phase.
- `run` in 1: one-cycle start pulse.
- `done` out 1: unit idle.
- `databus_valid_0` out 1 / `databus_ready_0` in 1: write beat handshake.
- `databus_addr_0` out AXI_ADDR_W: burst base address.
- `databus_wdata_0` out AXI_DATA_W.
- `databus_wstrb_0` out AXI_DATA_W/8.
- `databus_len_0` out LEN_W: beats−1.
- `databus_rdata_0` in AXI_DATA_W: unused.
- `databus_last_0` in 1: final beat accepted.
- `ext_dp_addr_0_port_0` out ADDR_W, `ext_dp_out_0_port_0` out AXI_DATA_W, `ext_dp_in_0_port_0` in AXI_DATA_W, `ext_dp_enable_0_port_0` out 1, `ext_dp_write_0_port_0` out 1: capture write port.
- `ext_dp_addr_0_port_1` out ADDR_W, `ext_dp_out_0_port_1` out AXI_DATA_W, `ext_dp_in_0_port_1` in AXI_DATA_W, `ext_dp_enable_0_port_1` out 1, `ext_dp_write_0_port_1` out 1: flush read port, 1-cycle read latency.
- `ext_addr` in AXI_ADDR_W: flush destination address.
- `disabled` in 1: unit bypass.
- `delay0` in 32: start-of-capture delay in cycles.
- `in0` in 32: event flag; nonzero means an event.
- `out0` out 32: events captured so far this run (versat_latency 1).
- `out1` out 32: overflow flag (see Configuration).

## Operation
- **Reset values:**
  - All outputs, `pingPong`, counters and delay: 0.
  - FSM: IDLE.
  - `databus_valid_0`: 0.
- **On `run`:**
  - `pingPong` toggles.
  - `flushCount` ← `capCount`, saturated at 2^LEN_W.
  - `capCount` ← 0, `cycle` ← 0, `delay` ← `delay0`, `overflow` ← 0.
  - `databus_addr_0` ← `ext_addr`.
  - FSM → FETCH if `flushCount` ≠ 0 and `!disabled`, else IDLE.
- **Capture:**
  - While `running && !run && delay==0`, `cycle` increments each cycle. While `delay` ≠ 0, `delay` decrements instead.
  - If `in0` ≠ 0 and `!disabled`, port 0 writes `cycle[SIZE_W-1:0]` (zero-extended) to `{pingPong, capCount[ADDR_W-2:0]}`, then `capCount`++.
  - Full half: when `capCount` == 2^(ADDR_W-1), further events are dropped.
- **Flush FSM** (reads half `!pingPong`):
  - IDLE: no activity.
  - FETCH: assert port 1 enable at index `idx` (write=0). Next state is SEND.
  - SEND: `databus_valid_0` = 1 and `wdata` = port-1 data, held until `ready`.
    - On `ready`: `idx`++.
    - If `databus_last_0` or `idx+1` == `flushCount`, go to IDLE; otherwise go to FETCH.
- **Fixed databus outputs:**
  - `databus_len_0` = `flushCount`−1.
  - `wstrb` = all ones.
- `out0` = `capCount`, registered (1 cycle).
- `done` = `!running || disabled || (FSM==IDLE && !databus_valid_0)`.
- **Boundary conditions:**
  - Event on the `run` cycle: not captured.
  - `run` during SEND: the flush restarts with the new `flushCount`. The framework never does this.
  - `rst` asserted mid-burst: `valid` drops immediately.

## Timing
- Capture write: same cycle as the event.
- `out0` reflects an event 1 cycle later.
- Flush throughput: 1 beat per 2 cycles plus ready stalls.
- First `valid`: 2 cycles after `run`.

## Configuration
- `TIMED_FLAG_CAPTURE_OVERFLOW_EN`:
  - Defined: an event arriving while full sets a sticky `overflow` bit, cleared on `run`. `out1` = {31'b0, `overflow`}.
  - Undefined: `out1` is tied to 0 and there is no overflow register. Events arriving while full are still dropped.

## Structure
- Shared package holds:
  - Flush FSM state typedef (IDLE, FETCH, SEND).
  - Localparams for half capacity (2^(ADDR_W-1)) and the maximum burst (2^LEN_W).
- One sub-module, `flag_flush_streamer`, contains the FETCH/SEND FSM, `idx`, port 1 and the databus beat logic.

## Test plan
- `delay0`=3; `in0` pulses at cycles 0, 5 and 9 after the delay expires; next `run` → bursts {0, 5, 9}, len=2, address = `ext_addr`, `out0`=3 before flush.
- No events captured; `run` → no databus `valid`; `done`=1 in the cycle after `run`.
- `databus_ready_0` held low for 10 cycles mid-burst → `wdata` and `valid` stay stable; all beats delivered in order.
- Event rate exceeding half capacity with the macro defined → `capCount` stops at 2^(ADDR_W-1), `out1`=1. With the macro undefined → `out1`=0.
- `disabled`=1 during a run with events → no memory writes, no flush, `done`=1 throughout.
- `rst` low during SEND → `valid` goes to 0 asynchronously, FSM returns to IDLE, `out0`=0.

Source files
------------

// File: rtl/timed_flag_capture_pkg.sv
// Shared types and sizing helpers for timed_flag_capture and its flush streamer.
// Optional feature macro: TIMED_FLAG_CAPTURE_OVERFLOW_EN (sticky overflow flag on out1).
package timed_flag_capture_pkg;

    // Flush FSM: IDLE waits for run, FETCH reads one word, SEND offers it on the databus.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } flush_state_t;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_LEN_W  = 8;

    // Entries in one ping-pong half: the address MSB selects the half.
    function automatic int unsigned half_cap(input int addr_w);
        return 32'd1 << (addr_w - 1);
    endfunction

    // Largest burst the length field can describe (len = beats - 1).
    function automatic int unsigned max_burst(input int len_w);
        return 32'd1 << len_w;
    endfunction

    localparam int unsigned HALF_CAP  = half_cap(DEF_ADDR_W);
    localparam int unsigned MAX_BURST = max_burst(DEF_LEN_W);

endpackage

// File: rtl/flag_flush_streamer.sv
// Flush streamer: reads the captured half one word at a time (1-cycle read
// latency) and offers each word as one databus write beat.
// Handshake: a beat transfers on a cycle where bus_valid && bus_ready; while
// bus_valid is high the beat (bus_wdata) is held unchanged until accepted.
// The memory port is not re-enabled during SEND, so its output stays stable.
module flag_flush_streamer
    import timed_flag_capture_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int AXI_DATA_W = 32,
    parameter int LEN_W      = DEF_LEN_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  go,
    input  logic [LEN_W:0]        flush_count,
    input  logic                  read_half,
    input  logic [AXI_DATA_W-1:0] rd_data,
    input  logic                  bus_ready,
    input  logic                  bus_last,
    output logic [ADDR_W-1:0]     rd_addr,
    output logic                  rd_enable,
    output logic                  bus_valid,
    output logic [AXI_DATA_W-1:0] bus_wdata,
    output flush_state_t          state
);

    localparam int IW = ADDR_W - 1;

    flush_state_t   state_next;
    logic [LEN_W:0] idx;
    logic [LEN_W:0] idx_next;
    logic [LEN_W:0] idx_inc;
    logic [IW-1:0]  idx_low;

    assign idx_inc   = idx + (LEN_W+1)'(1);
    assign idx_low   = IW'(idx);
    assign rd_addr   = {read_half, idx_low};
    assign bus_wdata = rd_data;

    // State and beat index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Next state, read enable and beat valid; a start pulse restarts the flush.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        rd_enable  = 1'b0;
        bus_valid  = 1'b0;
        case (state)
            FETCH: begin
                rd_enable  = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                bus_valid = 1'b1;
                if (bus_ready) begin
                    idx_next   = idx_inc;
                    state_next = (bus_last || (idx_inc == flush_count)) ? IDLE : FETCH;
                end
            end
            default: begin
            end
        endcase
        if (start) begin
            idx_next   = '0;
            state_next = go ? FETCH : IDLE;
        end
    end

endmodule

// File: rtl/timed_flag_capture.sv
// Timestamps every event cycle into one ping-pong half while running, and on
// the next run burst-writes that half to external memory.
// Optional feature macro: TIMED_FLAG_CAPTURE_OVERFLOW_EN (sticky overflow on out1).
module timed_flag_capture
    import timed_flag_capture_pkg::*;
#(
    parameter int SIZE_W     = 16,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int LEN_W      = DEF_LEN_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    running,
    input  logic                    run,
    output logic                    done,
    output logic                    databus_valid_0,
    input  logic                    databus_ready_0,
    output logic [AXI_ADDR_W-1:0]   databus_addr_0,
    output logic [AXI_DATA_W-1:0]   databus_wdata_0,
    output logic [AXI_DATA_W/8-1:0] databus_wstrb_0,
    output logic [LEN_W-1:0]        databus_len_0,
    input  logic [AXI_DATA_W-1:0]   databus_rdata_0,
    input  logic                    databus_last_0,
    output logic [ADDR_W-1:0]       ext_dp_addr_0_port_0,
    output logic [AXI_DATA_W-1:0]   ext_dp_out_0_port_0,
    input  logic [AXI_DATA_W-1:0]   ext_dp_in_0_port_0,
    output logic                    ext_dp_enable_0_port_0,
    output logic                    ext_dp_write_0_port_0,
    output logic [ADDR_W-1:0]       ext_dp_addr_0_port_1,
    output logic [AXI_DATA_W-1:0]   ext_dp_out_0_port_1,
    input  logic [AXI_DATA_W-1:0]   ext_dp_in_0_port_1,
    output logic                    ext_dp_enable_0_port_1,
    output logic                    ext_dp_write_0_port_1,
    input  logic [AXI_ADDR_W-1:0]   ext_addr,
    input  logic                    disabled,
    input  logic [31:0]             delay0,
    input  logic [31:0]             in0,
    output logic [31:0]             out0,
    output logic [31:0]             out1
);

    localparam int unsigned HALF = half_cap(ADDR_W);
    localparam int unsigned MAXB = max_burst(LEN_W);

    logic           ping_pong;
    logic [31:0]    cap_count;
    logic [31:0]    cycle;
    logic [31:0]    delay;
    logic [LEN_W:0] flush_count;
    logic [LEN_W:0] flush_count_next;
    logic [LEN_W:0] len_full;
    logic           capture_ok;
    logic           full;
    logic           capture_fire;
    logic           go;
    flush_state_t   fsm_state;
    logic           unused_ok;

    // An event counts only once the start delay has elapsed; run cycles never capture.
    assign capture_ok   = running && !run && (delay == 32'd0) && (in0 != 32'd0) && !disabled;
    assign full         = (cap_count == HALF);
    assign capture_fire = capture_ok && !full;

    assign flush_count_next = (cap_count > MAXB) ? (LEN_W+1)'(MAXB) : (LEN_W+1)'(cap_count);
    assign go               = (flush_count_next != '0) && !disabled;

    assign ext_dp_addr_0_port_0   = {ping_pong, cap_count[ADDR_W-2:0]};
    assign ext_dp_out_0_port_0    = AXI_DATA_W'(cycle[SIZE_W-1:0]);
    assign ext_dp_enable_0_port_0 = capture_fire;
    assign ext_dp_write_0_port_0  = capture_fire;
    assign ext_dp_out_0_port_1    = '0;
    assign ext_dp_write_0_port_1  = 1'b0;

    assign len_full        = flush_count - (LEN_W+1)'(1);
    assign databus_len_0   = len_full[LEN_W-1:0];
    assign databus_wstrb_0 = '1;

    assign done = !running || disabled || ((fsm_state == IDLE) && !databus_valid_0);

    assign unused_ok = ^{databus_rdata_0, ext_dp_in_0_port_0, len_full[LEN_W]};

    // Run bookkeeping, start delay, cycle counter and capture count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ping_pong      <= 1'b0;
            cap_count      <= '0;
            cycle          <= '0;
            delay          <= '0;
            flush_count    <= '0;
            databus_addr_0 <= '0;
            out0           <= '0;
        end else begin
            out0 <= cap_count;
            if (run) begin
                ping_pong      <= ~ping_pong;
                flush_count    <= flush_count_next;
                cap_count      <= '0;
                cycle          <= '0;
                delay          <= delay0;
                databus_addr_0 <= ext_addr;
            end else begin
                if (running) begin
                    if (delay != 32'd0) delay <= delay - 32'd1;
                    else                cycle <= cycle + 32'd1;
                end
                if (capture_fire) cap_count <= cap_count + 32'd1;
            end
        end
    end

`ifdef TIMED_FLAG_CAPTURE_OVERFLOW_EN
    logic overflow;

    // Sticky flag for an event that found the half already full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    overflow <= 1'b0;
        else if (run)                overflow <= 1'b0;
        else if (capture_ok && full) overflow <= 1'b1;
    end

    assign out1 = {31'b0, overflow};
`else
    assign out1 = '0;
`endif

    flag_flush_streamer #(
        .ADDR_W     (ADDR_W),
        .AXI_DATA_W (AXI_DATA_W),
        .LEN_W      (LEN_W)
    ) u_streamer (
        .clk         (clk),
        .rst_n       (rst),
        .start       (run),
        .go          (go),
        .flush_count (flush_count),
        .read_half   (~ping_pong),
        .rd_data     (ext_dp_in_0_port_1),
        .bus_ready   (databus_ready_0),
        .bus_last    (databus_last_0),
        .rd_addr     (ext_dp_addr_0_port_1),
        .rd_enable   (ext_dp_enable_0_port_1),
        .bus_valid   (databus_valid_0),
        .bus_wdata   (databus_wdata_0),
        .state       (fsm_state)
    );

endmodule
